// File: rtl/uart_rx_param_pkg.sv
// uart_rx_param_pkg: parity codes, FSM states and majority helper shared by the UART receiver
package uart_rx_param_pkg;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction
endpackage

// File: rtl/uart_rx_param_if.sv
// uart_rx_param_if: received-frame valid/ready handshake between receiver and consumer
interface uart_rx_param_if #(parameter int DATA_BITS = 8);
    logic [DATA_BITS-1:0] dout;
    logic rx_valid, rx_ready, frame_err, parity_err, break_det, overrun;
    modport master (output dout, rx_valid, frame_err, parity_err, break_det, overrun, input rx_ready);
    modport slave (input dout, rx_valid, frame_err, parity_err, break_det, overrun, output rx_ready);
endinterface

// File: rtl/uart_rx_param_sampler.sv
// uart_rx_param_sampler: 2-flop line synchroniser and 3-sample majority filter
module uart_rx_param_sampler
    import uart_rx_param_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic Data_in,
    input  logic tick,
    output logic maj,
    output logic line_low
);
    logic [1:0] sync;
    logic [2:0] samp;
    // synchronise every clk, shift a sample into the vote window only on tick
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync <= 2'b11;
            samp <= 3'b111;
        end else begin
            sync <= {sync[0], Data_in};
            if (tick) samp <= {samp[1:0], sync[1]};
        end
    end
    assign maj      = maj3(samp);
    assign line_low = ~sync[1];
endmodule

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised oversampling UART receiver with error flags and valid/ready output
module uart_rx_param
    import uart_rx_param_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input logic clk,
    input logic reset,
    input logic Data_in,
    input logic tick,
    uart_rx_param_if.master rx
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] MID   = TW'(OVERSAMPLE / 2);
    localparam logic [TW-1:0] LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BLAST = BW'(DATA_BITS - 1);
    localparam logic          SLAST = 1'(STOP_BITS - 1);
    state_t state, state_n;
    logic [TW-1:0] tcnt;
    logic [BW-1:0] bcnt;
    logic [DATA_BITS-1:0] shreg;
    logic scnt, armed, pbit, stop_lo, stop_hi, done;
    logic maj, line_low, at_end, bit_tick, frame_end, perr, brk, accept;
    uart_rx_param_sampler u_sampler (
        .clk(clk), .reset(reset), .Data_in(Data_in), .tick(tick), .maj(maj), .line_low(line_low)
    );
    assign at_end = tick && tcnt == LAST;
    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else state <= state_n;
    end
    // next state: start at mid-bit, then one decision per bit centre
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (tick && armed && line_low) state_n = S_START;
            S_START:  if (tick && tcnt == MID) state_n = maj ? S_IDLE : S_DATA;
            S_DATA:   if (at_end && bcnt == BLAST) state_n = (PARITY != PARITY_NONE) ? S_PARITY : S_STOP;
            S_PARITY: if (at_end) state_n = S_STOP;
            S_STOP:   if (at_end && scnt == SLAST) state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end
    // decoded strobes: sample a bit at its centre, flag the last stop sample
    always_comb begin
        bit_tick  = at_end && state != S_IDLE && state != S_START;
        frame_end = state == S_STOP && state_n == S_IDLE;
    end
    // counters, shift register and per-frame status; re-arm only after the line is seen high
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt    <= '0;
            bcnt    <= '0;
            scnt    <= 1'b0;
            shreg   <= '0;
            pbit    <= 1'b0;
            stop_lo <= 1'b0;
            stop_hi <= 1'b0;
            armed   <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= frame_end;
            tcnt <= (state != state_n || at_end) ? '0 : (tick && state != S_IDLE) ? tcnt + 1'b1 : tcnt;
            armed <= frame_end ? 1'b0 : (state == S_IDLE && tick && !line_low) ? 1'b1 : armed;
            if (state == S_START) begin
                bcnt    <= '0;
                scnt    <= 1'b0;
                pbit    <= 1'b0;
                stop_lo <= 1'b0;
                stop_hi <= 1'b0;
            end
            if (bit_tick && state == S_DATA) begin
                shreg <= {maj, shreg[DATA_BITS-1:1]};
                bcnt  <= bcnt + 1'b1;
            end
            if (bit_tick && state == S_PARITY) pbit <= maj;
            if (bit_tick && state == S_STOP) begin
                scnt    <= scnt + 1'b1;
                stop_lo <= stop_lo | ~maj;
                stop_hi <= stop_hi | maj;
            end
        end
    end
    assign perr   = (PARITY == PARITY_NONE) ? 1'b0 : (((^shreg) ^ pbit) != (PARITY == PARITY_ODD));
    assign brk    = shreg == '0 && !pbit && !stop_hi;
    assign accept = rx.rx_valid && rx.rx_ready;
    // output/handshake register: a completed frame is dropped (overrun) if the previous one is still held
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx.dout       <= '0;
            rx.rx_valid   <= 1'b0;
            rx.frame_err  <= 1'b0;
            rx.parity_err <= 1'b0;
            rx.break_det  <= 1'b0;
            rx.overrun    <= 1'b0;
        end else begin
            if (done && (!rx.rx_valid || accept)) begin
                rx.dout       <= shreg;
                rx.frame_err  <= stop_lo;
                rx.parity_err <= perr;
                rx.break_det  <= brk;
            end
            rx.rx_valid <= done || (rx.rx_valid && !rx.rx_ready);
            rx.overrun  <= (done && rx.rx_valid && !rx.rx_ready) ? 1'b1 : accept ? 1'b0 : rx.overrun;
        end
    end
endmodule

// File: tb/tb_uart_rx_param.sv
// tb_uart_rx_param: scoreboard bench for three receiver configurations (8N1, 7E1, 8N2)
module tb_uart_rx_param;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic tick = 1'b0;
    logic line [3];
    int checks = 0;
    int errors = 0;
    int tcount = 0;
    typedef struct packed {logic [8:0] d; logic fe; logic pe; logic bk; logic ov;} exp_t;
    exp_t sb [3][$];

    uart_rx_param_if #(.DATA_BITS(8)) ia ();
    uart_rx_param_if #(.DATA_BITS(7)) ib ();
    uart_rx_param_if #(.DATA_BITS(8)) ic ();

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) dut_a (
        .clk(clk), .reset(reset), .Data_in(line[0]), .tick(tick), .rx(ia));
    uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) dut_b (
        .clk(clk), .reset(reset), .Data_in(line[1]), .tick(tick), .rx(ib));
    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(2)) dut_c (
        .clk(clk), .reset(reset), .Data_in(line[2]), .tick(tick), .rx(ic));

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            tcount++;
            tick = (tcount % 3 == 0);
        end
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!tick) @(posedge clk);
        end
    endtask

    task automatic send(input int d, input int nbits, input logic [8:0] data, input int pmode,
                        input logic pflip, input int nstop, input logic [1:0] stops);
        logic p;
        p = 1'b0;
        wait_ticks(1);
        #1 line[d] = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < nbits; i++) begin
            p = p ^ data[i];
            #1 line[d] = data[i];
            wait_ticks(16);
        end
        if (pmode != 0) begin
            #1 line[d] = (pmode == 2 ? ~p : p) ^ pflip;
            wait_ticks(16);
        end
        for (int i = 0; i < nstop; i++) begin
            #1 line[d] = stops[i];
            wait_ticks(16);
        end
        #1 line[d] = 1'b1;
    endtask

    task automatic push(input int d, input logic [8:0] data, input logic fe, input logic pe,
                        input logic bk, input logic ov);
        sb[d].push_back({data, fe, pe, bk, ov});
    endtask

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, want);
        end
    endtask

    task automatic chk_frame(input int d, input exp_t a);
        exp_t e;
        checks++;
        if (sb[d].size() == 0) begin
            errors++;
            $display("FAIL frame%0d unexpected: got d=%h fe=%b pe=%b bk=%b ov=%b", d, a.d, a.fe, a.pe, a.bk, a.ov);
        end else begin
            e = sb[d].pop_front();
            if (a !== e) begin
                errors++;
                $display("FAIL frame%0d: got d=%h fe=%b pe=%b bk=%b ov=%b, want d=%h fe=%b pe=%b bk=%b ov=%b",
                         d, a.d, a.fe, a.pe, a.bk, a.ov, e.d, e.fe, e.pe, e.bk, e.ov);
            end
        end
    endtask

    task automatic drain(input int d);
        int n;
        n = 0;
        while (sb[d].size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (sb[d].size() != 0) begin
            errors++;
            $display("FAIL drain%0d: %0d frames pending, want 0", d, sb[d].size());
        end
    endtask

    always @(negedge clk) begin
        if (ia.rx_valid && ia.rx_ready)
            chk_frame(0, {1'b0, ia.dout, ia.frame_err, ia.parity_err, ia.break_det, ia.overrun});
        if (ib.rx_valid && ib.rx_ready)
            chk_frame(1, {2'b0, ib.dout, ib.frame_err, ib.parity_err, ib.break_det, ib.overrun});
        if (ic.rx_valid && ic.rx_ready)
            chk_frame(2, {1'b0, ic.dout, ic.frame_err, ic.parity_err, ic.break_det, ic.overrun});
    end

    task automatic check_reset(input string tag);
        check({tag, "_a_dout"}, {1'b0, ia.dout}, 9'h0);
        check({tag, "_a_flags"}, {4'b0, ia.rx_valid, ia.frame_err, ia.parity_err, ia.break_det, ia.overrun}, 9'h0);
        check({tag, "_b"}, {2'b0, ib.dout} | {4'b0, ib.rx_valid, ib.frame_err, ib.parity_err, ib.break_det, ib.overrun}, 9'h0);
        check({tag, "_c"}, {1'b0, ic.dout} | {4'b0, ic.rx_valid, ic.frame_err, ic.parity_err, ic.break_det, ic.overrun}, 9'h0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        line = '{1'b1, 1'b1, 1'b1};
        ia.rx_ready = 1'b1;
        ib.rx_ready = 1'b1;
        ic.rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset("reset");
        reset = 1'b1;
        wait_ticks(40);
        // 8N1 basic frames, back to back
        push(0, 9'hA5, 0, 0, 0, 0); send(0, 8, 9'hA5, 0, 0, 1, 2'b11);
        push(0, 9'h00, 0, 0, 0, 0); send(0, 8, 9'h00, 0, 0, 1, 2'b11);
        push(0, 9'hFF, 0, 0, 0, 0); send(0, 8, 9'hFF, 0, 0, 1, 2'b11);
        drain(0);
        // 7E1 good and flipped parity
        push(1, 9'h35, 0, 0, 0, 0); send(1, 7, 9'h35, 1, 0, 1, 2'b11);
        push(1, 9'h35, 0, 1, 0, 0); send(1, 7, 9'h35, 1, 1, 1, 2'b11);
        drain(1);
        // short glitch rejected, then a valid frame
        wait_ticks(1);
        #1 line[0] = 1'b0;
        wait_ticks(4);
        #1 line[0] = 1'b1;
        wait_ticks(40);
        push(0, 9'h3C, 0, 0, 0, 0); send(0, 8, 9'h3C, 0, 0, 1, 2'b11);
        drain(0);
        // break: 12 bit times low gives exactly one frame, re-arms after line high
        push(0, 9'h00, 1, 0, 1, 0);
        wait_ticks(1);
        #1 line[0] = 1'b0;
        wait_ticks(192);
        #1 line[0] = 1'b1;
        wait_ticks(40);
        drain(0);
        push(0, 9'h81, 0, 0, 0, 0); send(0, 8, 9'h81, 0, 0, 1, 2'b11);
        drain(0);
        // overrun: second frame lost while first is held
        ia.rx_ready = 1'b0;
        push(0, 9'h11, 0, 0, 0, 1);
        send(0, 8, 9'h11, 0, 0, 1, 2'b11);
        send(0, 8, 9'h22, 0, 0, 1, 2'b11);
        wait_ticks(4);
        #1;
        check("ovr_dout", {1'b0, ia.dout}, 9'h11);
        check("ovr_flag", {7'b0, ia.rx_valid, ia.overrun}, 9'h3);
        ia.rx_ready = 1'b1;
        @(posedge clk);
        #1 check("ovr_clear", {7'b0, ia.rx_valid, ia.overrun}, 9'h0);
        drain(0);
        // completion in the same cycle as accept
        ia.rx_ready = 1'b0;
        push(0, 9'h44, 0, 0, 0, 0);
        send(0, 8, 9'h44, 0, 0, 1, 2'b11);
        push(0, 9'h55, 0, 0, 0, 0);
        fork
            send(0, 8, 9'h55, 0, 0, 1, 2'b11);
            begin
                wait_ticks(1);
                wait_ticks(154);
                #1 ia.rx_ready = 1'b1;
                @(posedge clk);
                #1 ia.rx_ready = 1'b0;
            end
        join
        check("same_dout", {1'b0, ia.dout}, 9'h55);
        check("same_flags", {7'b0, ia.rx_valid, ia.overrun}, 9'h2);
        ia.rx_ready = 1'b1;
        drain(0);
        // asynchronous reset in the middle of a frame
        fork
            send(0, 8, 9'h5A, 0, 0, 1, 2'b11);
            begin
                wait_ticks(60);
                #2 reset = 1'b0;
                #1 check_reset("midrst");
            end
        join
        wait_ticks(10);
        reset = 1'b1;
        wait_ticks(40);
        push(0, 9'hC3, 0, 0, 0, 0); send(0, 8, 9'hC3, 0, 0, 1, 2'b11);
        drain(0);
        // two stop bits: good frame, then second stop low
        push(2, 9'h96, 0, 0, 0, 0); send(2, 8, 9'h96, 0, 0, 2, 2'b11);
        push(2, 9'h96, 1, 0, 0, 0); send(2, 8, 9'h96, 0, 0, 2, 2'b01);
        drain(2);
        wait_ticks(40);
        drain(0);
        drain(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
